// File: rtl/sound_arbiter_pkg.sv
// Shared types and default tone table for the sound arbiter and the game-level wiring around it.
package sound_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Default tone indices understood by the tone generator
  localparam logic [3:0] TONE_WELCOME = 4'd1;
  localparam logic [3:0] TONE_COUNT   = 4'd2;
  localparam logic [3:0] TONE_GO      = 4'd3;
  localparam logic [3:0] TONE_HIT     = 4'd4;

  // Default durations in ticks, matched to the tones above
  localparam logic [5:0] DUR_WELCOME  = 6'd8;
  localparam logic [5:0] DUR_COUNT    = 6'd2;
  localparam logic [5:0] DUR_GO       = 6'd4;
  localparam logic [5:0] DUR_HIT      = 6'd1;

endpackage

// File: rtl/sound_arbiter_priority_picker.sv
// Combinational fixed-priority picker: isolates the lowest set request bit.
module priority_picker #(
  parameter int REQ_COUNT = 4
) (
  input  logic [REQ_COUNT-1:0] req,
  output logic [REQ_COUNT-1:0] onehot,
  output logic                 valid
);

  // Two's-complement trick keeps only the lowest set bit
  assign onehot = req & (~req + REQ_COUNT'(1));
  assign valid  = |req;

endmodule

// File: rtl/sound_arbiter.sv
// Fixed-priority sharing of one tone generator among pulsed sound requesters, with a silent gap after each tone.
// Define SOUND_PREEMPT_EN to let a higher-priority pending request abort the current tone or gap.
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int REQ_COUNT = 4,
  parameter int TONE_W    = 4,
  parameter int DUR_W     = 6,
  parameter int GAP_TICKS = 2
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        tick,
  input  logic [REQ_COUNT-1:0]        reqVector,
  input  logic [REQ_COUNT*TONE_W-1:0] reqTones,
  input  logic [REQ_COUNT*DUR_W-1:0]  reqDurations,
  input  logic                        mute,
  output logic [TONE_W-1:0]           toneIndex,
  output logic                        toneEnable,
  output logic [REQ_COUNT-1:0]        grantVector,
  output logic                        busy
);

  state_e                 state_q, state_d;
  logic [REQ_COUNT-1:0]   pending_q, pending_d;
  logic [REQ_COUNT-1:0]   grant_q, grant_d;
  logic [TONE_W-1:0]      tone_q, tone_d;
  logic [DUR_W-1:0]       dur_q, dur_d;
  logic [DUR_W-1:0]       gap_q, gap_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;

  logic [REQ_COUNT-1:0]   pick_onehot_s;
  logic                   pick_valid_s;
  logic [TONE_W-1:0]      sel_tone_s;
  logic [DUR_W-1:0]       sel_raw_s;
  logic [DUR_W-1:0]       sel_dur_s;
  logic                   preempt_s;
  logic                   load_s;

  priority_picker #(.REQ_COUNT(REQ_COUNT)) u_picker (
    .req    (pending_q),
    .onehot (pick_onehot_s),
    .valid  (pick_valid_s)
  );

  // Mux the winning requester's tone and duration slices
  always_comb begin
    sel_tone_s = '0;
    sel_raw_s  = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      sel_tone_s = sel_tone_s | (reqTones[i*TONE_W +: TONE_W] & {TONE_W{pick_onehot_s[i]}});
      sel_raw_s  = sel_raw_s  | (reqDurations[i*DUR_W +: DUR_W] & {DUR_W{pick_onehot_s[i]}});
    end
    sel_dur_s = (sel_raw_s == '0) ? DUR_W'(1) : sel_raw_s;
  end

`ifdef SOUND_PREEMPT_EN
  logic [REQ_COUNT-1:0] cur_q, cur_d;

  // A lower one-hot value means a lower index, hence higher priority than the current requester
  assign preempt_s = pick_valid_s && (state_q != ST_IDLE) && (pick_onehot_s < cur_q);
  assign cur_d     = load_s ? pick_onehot_s : cur_q;

  // Remembers the current/last granted requester for the preemption compare
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cur_q <= '0;
    end else begin
      cur_q <= cur_d;
    end
  end
`else
  assign preempt_s = 1'b0;
`endif

  assign load_s = pick_valid_s && ((state_q == ST_IDLE) || preempt_s);

  // Next-state logic for sequencing, counters and the grant pulse
  always_comb begin
    state_d = state_q;
    tone_d  = tone_q;
    dur_d   = dur_q;
    gap_d   = gap_q;
    grant_d = '0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_PLAY: begin
        if (tick) begin
          if (dur_q == DUR_W'(1)) begin
            if (GAP_TICKS > 0) begin
              state_d = ST_GAP;
              gap_d   = DUR_W'(GAP_TICKS);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            dur_d = dur_q - DUR_W'(1);
          end
        end else begin
          dur_d = dur_q;
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_q == DUR_W'(1)) begin
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q - DUR_W'(1);
          end
        end else begin
          gap_d = gap_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A load (from IDLE or by preemption) overrides any counter activity this cycle
    if (load_s) begin
      state_d = ST_PLAY;
      tone_d  = sel_tone_s;
      dur_d   = sel_dur_s;
      grant_d = pick_onehot_s;
    end else begin
      grant_d = '0;
    end
  end

  assign pending_d = (pending_q & ~grant_d) | reqVector;
  assign en_d      = (state_d == ST_PLAY) && !mute;
  assign busy_d    = (state_d != ST_IDLE);

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      tone_q    <= '0;
      dur_q     <= '0;
      gap_q     <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      tone_q    <= tone_d;
      dur_q     <= dur_d;
      gap_q     <= gap_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
    end
  end

  assign toneIndex   = tone_q;
  assign toneEnable  = en_q;
  assign grantVector = grant_q;
  assign busy        = busy_q;

endmodule

// File: doc/sound_arbiter.md
# sound_arbiter

Shares the single tone generator among several sound requesters: game sequencing (countdown beeps, welcome tone), collision events and level-end events. It latches one-cycle request pulses, grants them in fixed priority order, and drives one tone index for a per-request duration. After each tone it inserts a silent gap. It sits between the game control logic and the audio tone generator.

## Interface
- `REQ_COUNT`, 4: number of requesters. Bit 0 has the highest priority.
- `TONE_W`, 4: tone index width.
- `DUR_W`, 6: duration counter width, in ticks.
- `GAP_TICKS`, 2: silent ticks after each tone. 0 means no gap.

Ports:
- `clk`  in  1  system clock. One clock only.
- `resetN`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  one-cycle time-base pulse for durations.
- `reqVector`  in  REQ_COUNT  one-cycle request pulses.
- `reqTones`  in  REQ_COUNT*TONE_W  tone index per requester. Slice i belongs to requester i.
- `reqDurations`  in  REQ_COUNT*DUR_W  duration in ticks per requester.
- `mute`  in  1  forces `toneEnable` low. Sequencing continues.
- `toneIndex`  out  TONE_W  tone currently selected.
- `toneEnable`  out  1  tone generator enable.
- `grantVector`  out  REQ_COUNT  one-hot, one-cycle pulse when a request starts playing.
- `busy`  out  1  high when state is not IDLE.

## Operation
- Every output is registered. Reset clears all outputs, `pending` and both counters, and sets state IDLE.
- Each `pending[i]` is set by `reqVector[i]` and cleared when requester i is granted.
  - If a set and a clear happen in the same cycle, set wins, so the request is queued again.
  - Repeated requests while pending collapse into one.
- State machine:
  - IDLE: if `pending` is nonzero, pick the lowest set index i. Load `toneIndex` from slice i and the duration counter from slice i, with 0 treated as 1. Pulse `grantVector[i]` and go to PLAY. Otherwise stay in IDLE.
  - PLAY: `toneEnable = !mute`. Each `tick` decrements the duration counter. When `tick` arrives with the counter at 1:
    - if GAP_TICKS > 0, go to GAP and load the gap counter with GAP_TICKS;
    - otherwise go to IDLE.
  - GAP: `toneEnable` is 0. Each `tick` decrements the gap counter. When `tick` arrives with the counter at 1, go to IDLE.
- `toneIndex` holds its last value outside PLAY.
- A `tick` in the cycle the tone is loaded is ignored. The audible duration is therefore between D−1 and D tick periods.
- `mute` changes take effect on the next cycle and do not stop counters.

## Timing
- `reqVector[i]` pulse at edge N → `pending[i]` set at N+1 → `grantVector[i]`, `toneEnable` and `toneIndex` valid after edge N+2. Request-to-sound latency is 2 cycles when idle.
- `grantVector` is high for exactly the first PLAY cycle.
- PLAY ends at the edge following the final tick. `toneEnable` falls that same cycle.
- From GAP to IDLE to the next grant is at least one cycle. Back-to-back tones therefore have at least GAP_TICKS ticks plus 1 cycle of silence.
- Simultaneous requests on several bits are served lowest index first. The others stay pending.
- A request from the currently playing requester during PLAY is queued and replays afterwards.
- `resetN` low mid-tone silences the output asynchronously and discards all pending requests.

## Configuration
- `SOUND_PREEMPT_EN` defined:
  - In PLAY or GAP, a pending request with a lower index than the current/last requester aborts the current tone.
  - The next cycle loads the new request as in IDLE, with a grant pulse and no gap.
  - The preempted request is dropped, not re-queued.
- Not defined: no preemption. The current tone always completes, followed by its gap.

## Structure
- Package `sound_pkg` holds:
  - the state enum (IDLE, PLAY, GAP);
  - default tone index constants (TONE_WELCOME, TONE_COUNT, TONE_GO, TONE_HIT);
  - default durations, for use by top-level wiring.
- Sub-module `priority_picker`: combinational, parameterised on REQ_COUNT. It returns the one-hot lowest set bit and a valid flag. The arbiter uses it in IDLE and for the preemption compare.

## Test plan
1. Reset, then a `reqVector=4'b0100` pulse with slice 2 = tone 5 and duration 3, ticks every 10 cycles:
   - `grantVector=4'b0100` 2 cycles later;
   - `toneEnable=1` with `toneIndex=5` for 3 ticks;
   - then 2 silent ticks, and `busy` drops.
2. Same-cycle `reqVector=4'b1010`: requester 1 is granted first, then requester 3 after the first tone and gap complete.
3. Duration slice = 0: the tone plays until the first tick after the load cycle, as if the duration were 1.
4. `mute=1` during a 4-tick tone: `toneEnable=0` from the next cycle and the tone still ends after 4 ticks. `mute=0` mid-tone re-enables the tone in the next cycle.
5. `SOUND_PREEMPT_EN`: a bit-3 tone is playing and bit 0 is requested. Expect:
   - `grantVector=4'b0001` within 2 cycles;
   - no bit-3 replay.
   Without the macro, bit 0 plays after bit 3's tone and gap.
6. `resetN` asserted mid-PLAY with pending `4'b0011`: all outputs are 0 immediately, and no grants occur after release.
